// File: rtl/ras_driver_pkg.sv
// Shared definitions for the return-address-stack driver: RISC-V control-flow opcodes,
// link-register test and FSM state type.
package ras_driver_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    IDLE,
    COROUTINE
  } ras_state_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/ras_driver_predecode.sv
// Combinational call/return/branch classification of one RISC-V instruction word.
module ras_predecode
  import ras_driver_pkg::*;
(
  input  logic [31:0] instr,
  output logic        call,
  output logic        ret,
  output logic        coroutine,
  output logic        br
);

  logic [6:0] opc;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [2:0] funct3;
  logic       jal;
  logic       jalr;
  logic       bxx;
  logic       unused_bits;

  assign opc    = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];

  assign jal  = (opc == OPC_JAL);
  assign jalr = (opc == OPC_JALR) && (funct3 == 3'b000);
  assign bxx  = (opc == OPC_BRANCH);

  assign call      = (jal | jalr) & is_link(rd);
  assign ret       = jalr & is_link(rs1) & (!is_link(rd) | (rs1 != rd));
  assign coroutine = ret & is_link(rd);
  // br means "needs a stack checkpoint", which covers every JALR as well
  assign br        = bxx | jalr;

  assign unused_bits = ^instr[31:20];

endmodule

// File: rtl/ras_driver.sv
// Fetch-side predecoder driving the return address stack, with return redirect,
// checkpoint throttling and a one-entry valid/ready slice towards decode.
module ras_driver
  import ras_driver_pkg::*;
#(
  parameter int unsigned PC_BITS    = 32,
  parameter int unsigned CKPT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               branch_resolved_i,
  input  logic               valid_i,
  input  logic [PC_BITS-1:0] pc_i,
  input  logic [31:0]        instr_i,
  output logic               ready_o,
  output logic               ras_push_o,
  output logic               ras_pop_o,
  output logic [PC_BITS-1:0] ras_new_entry_o,
  output logic               ras_is_branch_o,
  input  logic [PC_BITS-1:0] ras_pc_i,
  input  logic               ras_is_empty_i,
  output logic               redirect_valid_o,
  output logic [PC_BITS-1:0] redirect_pc_o,
  output logic               out_valid_o,
  output logic [PC_BITS-1:0] out_pc_o,
  output logic [31:0]        out_instr_o,
  input  logic               out_ready_i
);

  localparam int unsigned CNT_W = $clog2(CKPT_DEPTH + 1);

  ras_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [PC_BITS-1:0] link_q;
  logic [PC_BITS-1:0] link_nxt;
  logic               call, ret, coroutine, br;
  logic               acc;
  logic               cnt_full;
  logic               cnt_dec;

  ras_predecode u_predecode (
    .instr     (instr_i),
    .call      (call),
    .ret       (ret),
    .coroutine (coroutine),
    .br        (br)
  );

  assign link_nxt = pc_i + PC_BITS'(4);
  assign cnt_full = (cnt == CNT_W'(CKPT_DEPTH));
  assign cnt_dec  = branch_resolved_i && (cnt != '0);

  assign ready_o = (state == IDLE) && (!out_valid_o || out_ready_i) && !flush_i
                   && !(br && cnt_full);
  assign acc     = valid_i && ready_o;

  // Coroutine returns pop now and push next cycle because the stack favours push over pop
  always_comb begin
    state_nxt       = state;
    ras_push_o      = 1'b0;
    ras_pop_o       = 1'b0;
    ras_is_branch_o = 1'b0;
    ras_new_entry_o = '0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          ras_push_o      = call && !coroutine;
          ras_pop_o       = ret && !ras_is_empty_i;
          ras_is_branch_o = br;
          if (call && !coroutine) ras_new_entry_o = link_nxt;
          if (coroutine) state_nxt = COROUTINE;
        end
      end
      COROUTINE: begin
        state_nxt = IDLE;
        if (!flush_i) begin
          ras_push_o      = 1'b1;
          ras_new_entry_o = link_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      link_q <= '0;
    end else begin
      state <= state_nxt;
      if (acc && coroutine) link_q <= link_nxt;
      if (flush_i) cnt <= '0;
      else if (ras_is_branch_o && !cnt_dec) cnt <= cnt + CNT_W'(1);
      else if (!ras_is_branch_o && cnt_dec) cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else if (flush_i) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      redirect_valid_o <= ras_pop_o;
      if (ras_pop_o) redirect_pc_o <= ras_pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_pc_o    <= '0;
      out_instr_o <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (acc) begin
      out_valid_o <= 1'b1;
      out_pc_o    <= pc_i;
      out_instr_o <= instr_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
